// File: rtl/ark_stage.sv
// ark_stage: registered AES AddRoundKey stage behind MixColumns, with a 2-entry skid buffer.
// Ports: clk/rst (async active-high); in_valid/in_ready upstream handshake carrying
// in_mixed, in_unmixed, in_key, in_round; out_valid/out_ready downstream handshake
// carrying out_data (state ^ key), out_round, out_last (round == NR); err sticky
// round-sequence error.
// Optional feature: define ARK_ROUND_CHECK_EN to build the expected-round checker;
// otherwise err is tied to 0.
module ark_stage #(
   parameter int NR = 10,
   parameter int RW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [127:0]  in_mixed,
   input  logic [127:0]  in_unmixed,
   input  logic [127:0]  in_key,
   input  logic [RW-1:0] in_round,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [127:0]  out_data,
   output logic [RW-1:0] out_round,
   output logic          out_last,
   output logic          err
);
   typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;
   state_t r_state, w_state_nxt;
   logic [127:0] r_main_data, r_skid_data, w_res;
   logic [RW-1:0] r_main_round, r_skid_round;
   logic r_in_ready, w_in_fire, w_out_fire, w_load_main, w_load_skid, w_shift;
   // First and last rounds bypass MixColumns; rounds beyond NR are treated as mixed.
   assign w_res = ((in_round == '0 || in_round == RW'(NR)) ? in_unmixed : in_mixed) ^ in_key;
   assign w_in_fire = in_valid & r_in_ready;
   assign w_out_fire = out_valid & out_ready;
   assign w_shift = (r_state == S_TWO) & w_out_fire;
   assign w_load_main = w_in_fire & ((r_state == S_EMPTY) | w_out_fire);
   assign w_load_skid = w_in_fire & (r_state == S_ONE) & ~w_out_fire;
   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         S_EMPTY: w_state_nxt = w_in_fire ? S_ONE : S_EMPTY;
         S_ONE:   w_state_nxt = (w_in_fire & ~w_out_fire) ? S_TWO :
                                (~w_in_fire & w_out_fire) ? S_EMPTY : S_ONE;
         S_TWO:   w_state_nxt = w_out_fire ? S_ONE : S_TWO;
         default: w_state_nxt = S_EMPTY;
      endcase
   end
   // in_ready is registered from the next occupancy, so out_ready never reaches it combinationally.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_EMPTY;
         r_in_ready   <= 1'b0;
         r_main_data  <= '0;
         r_main_round <= '0;
         r_skid_data  <= '0;
         r_skid_round <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= (w_state_nxt != S_TWO);
         if (w_shift) begin
            r_main_data  <= r_skid_data;
            r_main_round <= r_skid_round;
         end else if (w_load_main) begin
            r_main_data  <= w_res;
            r_main_round <= in_round;
         end
         if (w_load_skid) begin
            r_skid_data  <= w_res;
            r_skid_round <= in_round;
         end
      end
   end
   assign in_ready  = r_in_ready;
   assign out_valid = (r_state != S_EMPTY);
   assign out_data  = r_main_data;
   assign out_round = r_main_round;
   assign out_last  = (r_main_round == RW'(NR));
`ifdef ARK_ROUND_CHECK_EN
   logic [RW-1:0] r_exp;
   logic r_err;
   // The counter follows in_round on every beat, so a mismatch resynchronises it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_exp <= '0;
         r_err <= 1'b0;
      end else if (w_in_fire) begin
         r_err <= r_err | (in_round != r_exp);
         r_exp <= (in_round == RW'(NR)) ? '0 : in_round + 1'b1;
      end
   end
   assign err = r_err;
`else
   assign err = 1'b0;
`endif
endmodule

// File: tb/tb_ark_stage.sv
// tb_ark_stage: scoreboard bench for ark_stage with directed vectors.
module tb_ark_stage;
   localparam int NR = 10;
   localparam int RW = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic in_valid, in_ready, out_valid, out_ready, out_last, err;
   logic [127:0] in_mixed, in_unmixed, in_key, out_data;
   logic [RW-1:0] in_round, out_round;
   typedef struct packed {
      logic [127:0] d;
      logic [RW-1:0] r;
      logic l;
   } exp_t;
   exp_t q[$];
   int cyc_q[$];
   int total = 0;
   int bad = 0;
   int cyc = 0;
   exp_t e;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;
   ark_stage #(.NR(NR), .RW(RW)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_mixed(in_mixed), .in_unmixed(in_unmixed), .in_key(in_key), .in_round(in_round),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_round(out_round), .out_last(out_last), .err(err)
   );
   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         cyc_q.push_back(cyc);
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_output: got round %0d data %h expected none", out_round, out_data);
         end else begin
            e = q.pop_front();
            chk("out_data", out_data, e.d);
            chk("out_round", 128'(out_round), 128'(e.r));
            chk("out_last", 128'(out_last), 128'(e.l));
         end
      end
   end
   task automatic send(input logic [127:0] m, input logic [127:0] u, input logic [127:0] k,
                       input logic [RW-1:0] r, input logic [127:0] ed);
      in_valid = 1'b1;
      in_mixed = m;
      in_unmixed = u;
      in_key = k;
      in_round = r;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready) begin
            q.push_back('{d: ed, r: r, l: (r == RW'(NR))});
            @(posedge clk);
            #1;
            return;
         end
      end
      total++;
      bad++;
      $display("FAIL send_timeout: round %0d not accepted in 50 cycles, required acceptance", r);
      in_valid = 1'b0;
   endtask
   task automatic drain();
      for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
      #1;
      chk("drain_empty", 128'(q.size()), 128'd0);
   endtask
   initial begin
      int n0;
      logic [127:0] k;
      in_valid = 1'b0;
      in_mixed = '0;
      in_unmixed = '0;
      in_key = '0;
      in_round = '0;
      out_ready = 1'b1;
      #2;
      chk("rst_in_ready", 128'(in_ready), 128'd0);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_out_data", out_data, 128'd0);
      chk("rst_out_round", 128'(out_round), 128'd0);
      chk("rst_out_last", 128'(out_last), 128'd0);
      chk("rst_err", 128'(err), 128'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 chk("post_rst_in_ready", 128'(in_ready), 128'd1);
      send('0, 128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f,
           4'd0, 128'h00102030405060708090a0b0c0d0e0f0);
      send('1, '0, '0, 4'd5, '1);
      send('1, '0, '0, 4'd10, '0);
      in_valid = 1'b0;
      drain();
      out_ready = 1'b0;
      send(128'h1, '1, 128'h10, 4'd1, 128'h11);
      send(128'h2, '1, 128'h20, 4'd2, 128'h22);
      in_mixed = 128'h3;
      in_key = 128'h30;
      in_round = 4'd3;
      @(negedge clk);
      chk("t3_full_in_ready", 128'(in_ready), 128'd0);
      chk("t3_full_out_valid", 128'(out_valid), 128'd1);
      @(negedge clk);
      chk("t3_hold_in_ready", 128'(in_ready), 128'd0);
      chk("t3_hold_queued", 128'(q.size()), 128'd2);
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      chk("t3_pre_drain_in_ready", 128'(in_ready), 128'd0);
      @(posedge clk);
      #1 chk("t3_reopen_in_ready", 128'(in_ready), 128'd1);
      send(128'h3, '1, 128'h30, 4'd3, 128'h33);
      in_valid = 1'b0;
      drain();
      n0 = cyc_q.size();
      for (int r = 0; r <= NR; r++) begin
         k = {120'd0, 8'(r)};
         send('1, '0, k, RW'(r), (r == 0 || r == NR) ? k : ~k);
      end
      in_valid = 1'b0;
      drain();
      chk("t4_count", 128'(cyc_q.size() - n0), 128'd11);
      if (cyc_q.size() >= n0 + 11) chk("t4_no_bubble", 128'(cyc_q[n0 + 10] - cyc_q[n0]), 128'd10);
      out_ready = 1'b0;
      send(128'h4, '0, 128'h40, 4'd4, 128'h44);
      send(128'h5, '0, 128'h50, 4'd5, 128'h55);
      in_valid = 1'b0;
      #3 rst = 1'b1;
      #1;
      chk("t5_async_out_valid", 128'(out_valid), 128'd0);
      chk("t5_async_in_ready", 128'(in_ready), 128'd0);
      q.delete();
      #3 rst = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t5_no_stale", 128'(out_valid), 128'd0);
      end
      chk("t5_in_ready", 128'(in_ready), 128'd1);
      @(posedge clk);
      #1;
      send('0, '0, 128'ha0, 4'd0, 128'ha0);
      send('0, '0, 128'ha1, 4'd1, 128'ha1);
      chk("t6_err_ok_seq", 128'(err), 128'd0);
      send('0, '0, 128'ha3, 4'd3, 128'ha3);
      in_valid = 1'b0;
`ifdef ARK_ROUND_CHECK_EN
      chk("t6_err_rise", 128'(err), 128'd1);
`else
      chk("t6_err_rise", 128'(err), 128'd0);
`endif
      send('0, '0, 128'ha4, 4'd4, 128'ha4);
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
`ifdef ARK_ROUND_CHECK_EN
      chk("t6_err_sticky", 128'(err), 128'd1);
`else
      chk("t6_err_sticky", 128'(err), 128'd0);
`endif
      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at 200000, required completion");
      $fatal(1);
   end
endmodule
